fme_half_sel: RTL and testbench

FME_HALF_SEL -- requirements
Module: fme_half_sel

---
 rtl/fme_half_sel.sv | 109 ++++++++++
 tb/tb_fme_half_sel.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fme_half_sel.sv
// Fractional motion-estimation half-pel selector: accumulates nine candidate SADs over
// one block, then scans them serially and presents the cheapest candidate.
module fme_half_sel #(
   parameter int NPIX  = 16,
   parameter int SAD_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [71:0]      half_in,
   input  logic [7:0]       cur_pix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       best_idx,
   output logic [SAD_W-1:0] best_sad
);

   localparam int            PW       = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
   localparam logic [3:0]    CMP_LAST = 4'd8;

   typedef enum logic [1:0] {ACC, CMP, OUT} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    pix_cnt;
   logic [3:0]       cmp_cnt;
   logic [SAD_W-1:0] acc  [9];
   logic [SAD_W-1:0] absd [9];
   logic             beat;
   logic [3:0]       sel;
   logic [SAD_W-1:0] cand;
   logic             take;
   logic [3:0]       run_idx, win_idx;
   logic [SAD_W-1:0] run_sad, win_sad;

   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);
   assign beat      = in_valid && in_ready;

   for (genvar k = 0; k < 9; k++) begin : g_abs
      logic [7:0] px;
      logic [7:0] d;
      assign px      = half_in[8*k +: 8];
      assign d       = (px >= cur_pix) ? px - cur_pix : cur_pix - px;
      assign absd[k] = SAD_W'(d);
   end

   // Scan order puts the integer-pel sample first so that strict "<" favours it on ties.
   always_comb begin
      if (cmp_cnt == 4'd0)
         sel = 4'd4;
      else if (cmp_cnt <= 4'd4)
         sel = cmp_cnt - 4'd1;
      else
         sel = cmp_cnt;
   end

   assign cand    = acc[sel];
   assign take    = (cmp_cnt == 4'd0) || (cand < run_sad);
   assign win_idx = take ? sel  : run_idx;
   assign win_sad = take ? cand : run_sad;

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         ACC: if (beat && pix_cnt == PIX_LAST) state_nxt = CMP;
         CMP: if (cmp_cnt == CMP_LAST)         state_nxt = OUT;
         OUT: if (out_ready)                   state_nxt = ACC;
         default:                              state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACC;
         pix_cnt  <= '0;
         cmp_cnt  <= '0;
         best_idx <= 4'd4;
         best_sad <= '0;
      end else begin
         state <= state_nxt;
         if (beat)
            pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PW'(1);
         if (state == CMP) begin
            cmp_cnt <= (cmp_cnt == CMP_LAST) ? 4'd0 : cmp_cnt + 4'd1;
            if (cmp_cnt == CMP_LAST) begin
               best_idx <= win_idx;
               best_sad <= win_sad;
            end
         end
      end
   end

   // NOTE: accumulators and the running best are deliberately not reset; the first beat
   // of a block loads them and the first scan visit overwrites the running best.
   always_ff @(posedge clk) begin
      if (beat) begin
         for (int k = 0; k < 9; k++)
            acc[k] <= (pix_cnt == '0) ? absd[k] : acc[k] + absd[k];
      end
      if (state == CMP) begin
         run_idx <= win_idx;
         run_sad <= win_sad;
      end
   end

endmodule

// File: tb/tb_fme_half_sel.sv
// Self-checking bench for fme_half_sel: directed vector table, reset-abort sequence and
// randomized blocks with gaps/backpressure scored against an argmin-of-sums model.
module tb_fme_half_sel;

   localparam int NPIX  = 16;
   localparam int SAD_W = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [71:0]      half_in;
   logic [7:0]       cur_pix;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       best_idx;
   logic [SAD_W-1:0] best_sad;

   always #5 clk = ~clk;

   fme_half_sel #(.NPIX(NPIX), .SAD_W(SAD_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .half_in(half_in), .cur_pix(cur_pix), .out_valid(out_valid),
      .out_ready(out_ready), .best_idx(best_idx), .best_sad(best_sad)
   );

   typedef struct {
      string      name;
      logic [7:0] cur;
      logic [7:0] cand [9];
      int         e_idx;
      int         e_sad;
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] blk_c   [NPIX][9];
   logic [7:0] blk_cur [NPIX];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         prev_idx = 4;
   int         prev_sad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: total |cand - cur| per candidate, pick the minimum; index 4 wins any tie
   // it is part of, otherwise the lowest tied index.
   task automatic model(input int nbeats, output int idx, output int sad);
      int sums [9];
      int mn;
      for (int k = 0; k < 9; k++) begin
         sums[k] = 0;
         for (int b = 0; b < nbeats; b++)
            sums[k] += (blk_c[b][k] > blk_cur[b]) ? int'(blk_c[b][k]) - int'(blk_cur[b])
                                                  : int'(blk_cur[b]) - int'(blk_c[b][k]);
      end
      mn = sums[0];
      for (int k = 1; k < 9; k++) if (sums[k] < mn) mn = sums[k];
      idx = -1;
      if (sums[4] == mn) idx = 4;
      for (int k = 0; k < 9; k++) if (idx < 0 && sums[k] == mn) idx = k;
      sad = mn;
   endtask

   task automatic drive_beat(input int b);
      int g;
      @(negedge clk);
      in_valid = 1'b1;
      for (int k = 0; k < 9; k++) half_in[8*k +: 8] = blk_c[b][k];
      cur_pix = blk_cur[b];
      g = 0;
      while (!in_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (g >= 20) check("in_ready_timeout", 0, 1);
   endtask

   task automatic run_block(input string name, input bit gaps, input int stall);
      int lat, e_idx, e_sad, h_idx, h_sad;
      for (int b = 0; b < NPIX; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               in_valid = 1'b0;
               half_in  = {$urandom, $urandom, $urandom};
               cur_pix  = 8'($urandom);
            end
         end
         drive_beat(b);
      end
      lat = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (out_valid || lat >= 40) break;
         check({name, "_busy_in_ready"}, 32'(in_ready), 0);
         check({name, "_retain_idx"}, 32'(best_idx), prev_idx);
         check({name, "_retain_sad"}, 32'(best_sad), prev_sad);
         in_valid = 1'($urandom);
         half_in  = {$urandom, $urandom, $urandom};
         cur_pix  = 8'($urandom);
      end
      check({name, "_latency"}, lat, 10);
      if (!out_valid) return;
      model(NPIX, e_idx, e_sad);
      check({name, "_idx"}, 32'(best_idx), e_idx);
      check({name, "_sad"}, 32'(best_sad), e_sad);
      h_idx = best_idx;
      h_sad = best_sad;
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;
         half_in  = {$urandom, $urandom, $urandom};
         @(negedge clk);
         check({name, "_stall_valid"}, 32'(out_valid), 1);
         check({name, "_stall_in_ready"}, 32'(in_ready), 0);
         check({name, "_stall_idx"}, 32'(best_idx), h_idx);
         check({name, "_stall_sad"}, 32'(best_sad), h_sad);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_post_valid"}, 32'(out_valid), 0);
      check({name, "_post_in_ready"}, 32'(in_ready), 1);
      prev_idx = e_idx;
      prev_sad = e_sad;
   endtask

   task automatic fill_const(input logic [7:0] cur, input logic [7:0] cand [9]);
      for (int b = 0; b < NPIX; b++) begin
         blk_cur[b] = cur;
         for (int k = 0; k < 9; k++) blk_c[b][k] = cand[k];
      end
   endtask

   initial begin
      vecs[0] = '{"uniform",  8'd100, '{default: 8'd100}, 4, 0};
      vecs[1] = '{"single",   8'd50,  '{60, 60, 60, 60, 60, 60, 60, 52, 60}, 7, 32};
      vecs[2] = '{"tie_low",  8'd0,   '{20, 20, 3, 20, 10, 20, 3, 20, 20}, 2, 48};
      vecs[3] = '{"tie_four", 8'd0,   '{20, 20, 3, 20, 3, 20, 3, 20, 20}, 4, 48};
      vecs[4] = '{"max",      8'd0,   '{default: 8'd255}, 4, 4080};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; half_in = '0; cur_pix = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_best_idx", 32'(best_idx), 4);
      check("rst_best_sad", 32'(best_sad), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 1);

      for (int i = 0; i < 5; i++) begin
         fill_const(vecs[i].cur, vecs[i].cand);
         run_block(vecs[i].name, 1'b0, (i == 1) ? 5 : 0);
         check({vecs[i].name, "_tbl_idx"}, 32'(best_idx), vecs[i].e_idx);
         check({vecs[i].name, "_tbl_sad"}, 32'(best_sad), vecs[i].e_sad);
      end

      // Abort a block after 7 beats whose data would make candidate 1 lose badly.
      for (int b = 0; b < 7; b++) begin
         blk_cur[b] = 8'd80;
         for (int k = 0; k < 9; k++) blk_c[b][k] = (k == 1) ? 8'd200 : 8'd90;
         drive_beat(b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_in_ready", 32'(in_ready), 1);
      check("abort_best_idx", 32'(best_idx), 4);
      check("abort_best_sad", 32'(best_sad), 0);
      rst = 1'b0;
      prev_idx = 4;
      prev_sad = 0;
      for (int b = 0; b < NPIX; b++) begin
         blk_cur[b] = 8'd80;
         for (int k = 0; k < 9; k++) blk_c[b][k] = (k == 1) ? 8'd81 : 8'd90;
      end
      run_block("abort_next", 1'b1, 2);
      check("abort_tbl_idx", 32'(best_idx), 1);
      check("abort_tbl_sad", 32'(best_sad), 16);

      for (int r = 0; r < 8; r++) begin
         for (int b = 0; b < NPIX; b++) begin
            blk_cur[b] = (r < 2) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            for (int k = 0; k < 9; k++)
               blk_c[b][k] = (r < 2) ? 8'($urandom_range(0, 2)) : 8'($urandom);
         end
         run_block($sformatf("rand%0d", r), 1'b1, (r == 3) ? 5 : $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
